// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data memory between the CPU LSU and a debug/DMA port.
// Ports: clk, rst_n (async, active-low); cpu_* / dbg_* requester ports (req, we, addr, wdata,
//   sign_mask in; gnt, ack, rdata, err out); mem_* command registers out; mem_read_data and
//   mem_clk_stall in from the memory.
// Build option: define DATA_MEM_ARB_RR_EN for round-robin arbitration, otherwise the CPU has fixed priority.
module data_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_sign_mask,
  output logic        cpu_gnt,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic [3:0]  dbg_sign_mask,
  output logic        dbg_gnt,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        dbg_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_sign_mask,
  output logic        mem_memread,
  output logic        mem_memwrite,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;
  state_t state, state_n;
  logic owner_dbg, owner_we, seen_stall, pick_dbg, issue, done, tmo, fin, sel_we;
  logic [7:0] cnt;
`ifdef DATA_MEM_ARB_RR_EN
  logic last_dbg;
  // On a tie the port that was not granted last wins.
  assign pick_dbg = dbg_req & (~cpu_req | ~last_dbg);
`else
  assign pick_dbg = dbg_req & ~cpu_req;
`endif
  assign sel_we = pick_dbg ? dbg_we : cpu_we;
  assign fin = done | tmo;
  always_comb begin
    state_n = state;
    issue = 1'b0;
    done = 1'b0;
    tmo = 1'b0;
    case (state)
      IDLE: begin
        // A stall seen in IDLE is a leftover operation (e.g. across a reset): wait it out.
        issue = ~mem_clk_stall & (cpu_req | dbg_req);
        state_n = issue ? ISSUE : IDLE;
      end
      ISSUE: state_n = BUSY;
      BUSY: begin
        done = seen_stall & ~mem_clk_stall;
        tmo = ~done & (cnt == 8'(TIMEOUT_CYCLES - 1));
        state_n = (done | tmo) ? IDLE : BUSY;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
`ifdef DATA_MEM_ARB_RR_EN
      last_dbg <= 1'b1;
`endif
      owner_dbg <= 1'b0;
      owner_we <= 1'b0;
      seen_stall <= 1'b0;
      cnt <= '0;
      cpu_gnt <= 1'b0;
      cpu_ack <= 1'b0;
      cpu_rdata <= '0;
      cpu_err <= 1'b0;
      dbg_gnt <= 1'b0;
      dbg_ack <= 1'b0;
      dbg_rdata <= '0;
      dbg_err <= 1'b0;
      mem_addr <= '0;
      mem_write_data <= '0;
      mem_sign_mask <= '0;
      mem_memread <= 1'b0;
      mem_memwrite <= 1'b0;
    end else begin
      state <= state_n;
      cpu_gnt <= issue & ~pick_dbg;
      dbg_gnt <= issue & pick_dbg;
      mem_memread <= issue & ~sel_we;
      mem_memwrite <= issue & sel_we;
      cpu_ack <= fin & ~owner_dbg;
      dbg_ack <= fin & owner_dbg;
      if (issue) begin
`ifdef DATA_MEM_ARB_RR_EN
        last_dbg <= pick_dbg;
`endif
        owner_dbg <= pick_dbg;
        owner_we <= sel_we;
        mem_addr <= pick_dbg ? dbg_addr : cpu_addr;
        mem_write_data <= pick_dbg ? dbg_wdata : cpu_wdata;
        mem_sign_mask <= pick_dbg ? dbg_sign_mask : cpu_sign_mask;
      end
      if (state == ISSUE) begin
        seen_stall <= 1'b0;
        cnt <= '0;
      end else if (state == BUSY) begin
        seen_stall <= seen_stall | mem_clk_stall;
        cnt <= cnt + 8'd1;
      end
      if (fin && owner_dbg) dbg_err <= tmo;
      if (fin && !owner_dbg) cpu_err <= tmo;
      // Timeout forces rdata to 0; a good completion updates rdata only for loads.
      if ((tmo || (done && !owner_we)) && owner_dbg) dbg_rdata <= tmo ? '0 : mem_read_data;
      if ((tmo || (done && !owner_we)) && !owner_dbg) cpu_rdata <= tmo ? '0 : mem_read_data;
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: randomized/directed self-checking bench with a transaction-level arbiter model.
module tb_data_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [3:0] cpu_sign_mask, dbg_sign_mask;
  logic cpu_gnt, cpu_ack, cpu_err, dbg_gnt, dbg_ack, dbg_err;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_write_data, mem_read_data;
  logic [3:0] mem_sign_mask;
  logic mem_memread, mem_memwrite, mem_clk_stall;
  int checks = 0, passed = 0, ndbg = 0;
  bit exp_last = 1'b1;
  logic [31:0] exp_crd = '0, exp_drd = '0;
  logic [31:0] ref_mem [256];
  always #5 clk = ~clk;
  data_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_sign_mask(cpu_sign_mask), .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_sign_mask(dbg_sign_mask), .dbg_gnt(dbg_gnt), .dbg_ack(dbg_ack),
    .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_sign_mask(mem_sign_mask),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall)
  );
  function automatic logic [31:0] init_word(input int i);
    return (i == 2) ? 32'hDEADBEEF : (32'hA5000000 ^ (32'(i) * 32'h9E3779B1));
  endfunction
  // Memory environment: command sampled at the edge closing its cycle, one stall cycle, then data.
  logic [31:0] mem [256];
  bit inited = 1'b0, hang = 1'b0, phase = 1'b0, c_rd, c_wr, p_rd;
  logic [31:0] c_addr, c_wd, p_addr, p_wd;
  always @(negedge clk) begin
    c_rd = mem_memread;
    c_wr = mem_memwrite;
    c_addr = mem_addr;
    c_wd = mem_write_data;
  end
  always @(posedge clk) begin
    #1;
    if (!inited) begin
      for (int i = 0; i < 256; i++) mem[i] = init_word(i);
      inited = 1'b1;
    end
    if (hang) begin
      mem_clk_stall = 1'b1;
      phase = 1'b0;
    end else if (phase) begin
      mem_clk_stall = 1'b0;
      phase = 1'b0;
      if (p_rd) mem_read_data = mem[p_addr[9:2]];
      else begin
        mem[p_addr[9:2]] = p_wd;
        mem_read_data = $urandom;
      end
    end else begin
      mem_clk_stall = c_rd | c_wr;
      phase = c_rd | c_wr;
      p_rd = c_rd;
      p_addr = c_addr;
      p_wd = c_wd;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  function automatic bit winner(input bit c, input bit d);
`ifdef DATA_MEM_ARB_RR_EN
    return (c && d) ? !exp_last : d;
`else
    return !c;
`endif
  endfunction
  // Called at the falling edge of an IDLE cycle; returns at the falling edge of the ack cycle.
  task automatic txn(input bit c, input bit d, input bit rnd);
    bit w, we;
    logic [31:0] a, wd;
    logic [3:0] sm;
    if (rnd && c && !cpu_req) begin
      cpu_we = 1'($urandom);
      cpu_addr = 32'h4000 | ($urandom & 32'h3FC);
      cpu_wdata = $urandom;
      cpu_sign_mask = 4'($urandom);
    end
    if (rnd && d && !dbg_req) begin
      dbg_we = 1'($urandom);
      dbg_addr = 32'h4000 | ($urandom & 32'h3FC);
      dbg_wdata = $urandom;
      dbg_sign_mask = 4'($urandom);
    end
    cpu_req = c;
    dbg_req = d;
    w = winner(c, d);
    we = w ? dbg_we : cpu_we;
    a = w ? dbg_addr : cpu_addr;
    wd = w ? dbg_wdata : cpu_wdata;
    sm = w ? dbg_sign_mask : cpu_sign_mask;
    @(negedge clk);
    chk("gnt", {cpu_gnt, dbg_gnt}, w ? 2'b01 : 2'b10);
    chk("cmd_rw", {mem_memread, mem_memwrite}, we ? 2'b01 : 2'b10);
    chk("cmd_addr", mem_addr, a);
    chk("cmd_wdata", mem_write_data, wd);
    chk("cmd_sign_mask", {28'd0, mem_sign_mask}, {28'd0, sm});
    if (w) dbg_req = 1'b0;
    else cpu_req = 1'b0;
    exp_last = w;
    if (w) ndbg++;
    repeat (2) begin
      @(negedge clk);
      chk("busy_quiet", {cpu_gnt, dbg_gnt, cpu_ack, dbg_ack, mem_memread, mem_memwrite}, 0);
    end
    @(negedge clk);
    if (we) ref_mem[a[9:2]] = wd;
    else if (w) exp_drd = ref_mem[a[9:2]];
    else exp_crd = ref_mem[a[9:2]];
    chk("ack", {cpu_ack, dbg_ack, cpu_gnt, dbg_gnt}, w ? 4'b0100 : 4'b1000);
    chk("err", w ? dbg_err : cpu_err, 0);
    chk("cpu_rdata", cpu_rdata, exp_crd);
    chk("dbg_rdata", dbg_rdata, exp_drd);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {cpu_gnt, cpu_ack, cpu_err, dbg_gnt, dbg_ack, dbg_err, mem_memread, mem_memwrite}, 0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
    chk({tag, "_dbg_rdata"}, dbg_rdata, 0);
    chk({tag, "_mem_fields"}, mem_addr | mem_write_data | {28'd0, mem_sign_mask}, 0);
  endtask
  initial begin
    bit early;
    bit c, d;
    rst_n = 1'b0;
    {cpu_req, cpu_we, dbg_req, dbg_we} = '0;
    {cpu_addr, cpu_wdata, dbg_addr, dbg_wdata} = '0;
    {cpu_sign_mask, dbg_sign_mask} = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 32'h4008; cpu_wdata = 32'h0; cpu_sign_mask = 4'h2;
    txn(1'b1, 1'b0, 1'b0);
    chk("cpu_load_deadbeef", cpu_rdata, 32'hDEADBEEF);
    dbg_we = 1'b1; dbg_addr = 32'h4010; dbg_wdata = 32'h12345678; dbg_sign_mask = 4'h4;
    txn(1'b0, 1'b1, 1'b0);
    chk("dbg_store_rdata_kept", dbg_rdata, 32'h0);
    ndbg = 0;
    for (int k = 0; k < 8; k++) txn(1'b1, 1'b1, 1'b1);
`ifdef DATA_MEM_ARB_RR_EN
    chk("tie_dbg_grants", ndbg, 4);
`else
    chk("tie_dbg_grants", ndbg, 0);
`endif
    repeat (2) if (cpu_req || dbg_req) txn(cpu_req, dbg_req, 1'b0);
    for (int k = 0; k < 24; k++) begin
      if (!cpu_req && !dbg_req) repeat ($urandom_range(0, 2)) @(negedge clk);
      c = 1'($urandom);
      d = 1'($urandom);
      if (!c && !d && !cpu_req && !dbg_req) c = 1'b1;
      txn(c | cpu_req, d | dbg_req, 1'b1);
    end
    repeat (2) if (cpu_req || dbg_req) txn(cpu_req, dbg_req, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cpu_we = 1'b0;
      cpu_addr = 32'h4000 | ($urandom & 32'h3FC);
      txn(1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 32'h4020; cpu_req = 1'b1;
    @(negedge clk);
    chk("to_gnt", {cpu_gnt, dbg_gnt}, 2'b10);
    cpu_req = 1'b0;
    hang = 1'b1;
    exp_last = 1'b0;
    early = 1'b0;
    repeat (15) begin
      @(negedge clk);
      early |= cpu_ack | dbg_ack;
    end
    chk("to_no_early_ack", early, 0);
    @(negedge clk);
    chk("to_ack_err", {cpu_ack, cpu_err, dbg_ack}, 3'b110);
    chk("to_rdata_zero", cpu_rdata, 0);
    exp_crd = '0;
    hang = 1'b0;
    @(negedge clk);
    chk("to_idle_quiet", {cpu_ack, cpu_gnt, dbg_gnt, mem_memread, mem_memwrite}, 0);
    txn(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 32'h4044; cpu_req = 1'b1;
    @(negedge clk);
    chk("rst_pre_gnt", cpu_gnt, 1);
    hang = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("mid_reset");
    exp_last = 1'b1;
    exp_crd = '0;
    exp_drd = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_blocks_gnt", {cpu_gnt, dbg_gnt, cpu_ack, dbg_ack, mem_memread}, 0);
    end
    hang = 1'b0;
    @(negedge clk);
    chk("stall_release_no_gnt_yet", cpu_gnt, 0);
    txn(1'b1, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
